pixel_frame_source: RTL
=======================

// Module: pixel_frame_source
// PURPOSE
//  Raster-order pixel stream transmitter feeding median_filter (drives its start_i and pixel_valid_if slave).
//  Reads one full frame from a synchronous-read frame-buffer RAM and emits it on a valid-only pixel_valid_if master.
//  Programmable inter-pixel gap and a pause input exercise the filter's gapped-valid handling.
//  Pulses done_o when the last pixel has been sent.
// PARAMETERS
//  IMAGE_LEN    1080  pixels per row
//  IMAGE_HEIGHT 720   rows per frame
//  GAP_W        4     width of gap_cycles_i
// PORTS
//  clk              in   1          clock
//  rst              in   1          reset, synchronous, active-high
//  start_i          in   1          begin frame; sampled only in IDLE
//  gap_cycles_i     in   GAP_W      idle cycles between pixels; latched on accepted start_i
//  pause_i          in   1          hold off new reads while high
//  mem_rd_addr_o    out  ADDR_W     linear frame address, ADDR_W=$clog2(IMAGE_LEN*IMAGE_HEIGHT)
//  mem_rd_data_i    in   3*PIXEL_W  {red,green,blue}, red in MSBs; valid 1 cycle after address
//  filter_start_o   out  1          1-cycle pulse to median_filter start_i
//  busy_o           out  1          high whenever state != IDLE
//  done_o           out  1          1-cycle pulse, frame fully sent
//  pixel_valid_if_o master if       valid + pixel.{red,green,blue} (PIXEL_W each, median_filter_pkg)
// BEHAVIOUR
//  Reset: state=IDLE; addr counter, gap counter, rd_pending, valid, pixel fields, filter_start_o, done_o, busy_o all 0.
//  States: IDLE -> READ -> (GAP) -> READ ... -> DRAIN -> IDLE.
//   IDLE: start_i=1 -> latch gap_cycles_i, addr=0, filter_start_o=1 next cycle, go READ.
//   READ: if !pause_i: drive addr, set rd_pending, then either
//    last addr (IMAGE_LEN*IMAGE_HEIGHT-1) -> DRAIN;
//    gap=0 -> addr+1, stay READ; gap>0 -> addr+1, load gap counter, go GAP.
//    pause_i=1: no read issued, addr held.
//   GAP: decrement each cycle pause_i=0; at 1 -> READ. Pause freezes counter.
//   DRAIN: wait for final in-flight pixel; done_o=1 on the cycle after its valid; go IDLE.
//  Datapath: rd_pending registered with address; cycle after, RAM data registered into the output pixel
//   with valid=1. Address->valid latency 2 cycles. Pixel fields forced 0 when valid=0.
//  Timing: start_i sampled cycle 0 -> filter_start_o and addr 0 in cycle 1 -> first valid in cycle 3.
//  Throughput: gap=0 gives one valid per cycle; gap=G gives valids exactly G+1 cycles apart (no pause).
//  Valid-only protocol: no backpressure; an in-flight read always emits even if pause_i rises.
//  start_i outside IDLE ignored; no second filter_start_o pulse. gap_cycles_i changes mid-frame ignored.
//  Exactly IMAGE_LEN*IMAGE_HEIGHT valids per frame, addresses 0..N-1 in order, none repeated or skipped.
//  done_o and start_i in the same cycle: start_i ignored (state still DRAIN); accepted from the next cycle.
//  rst mid-frame: all outputs return to reset values the next cycle; no done_o; next start_i restarts at addr 0.
// TESTING
//  (IMAGE_LEN=4, IMAGE_HEIGHT=3, RAM preloaded mem[k]={k,k+16,k+32})
//  1. gap=0, start_i -> filter_start_o pulse cycle 1; 12 consecutive valids cycles 3..14 with mem[0..11];
//     done_o cycle 15.
//  2. gap=2 -> 12 valids spaced exactly 3 cycles apart, data in order; done_o 1 cycle after last valid.
//  3. gap=0, pause_i high 5 cycles after 4th pixel -> at most 1 further valid, then none for 5 cycles;
//     resume with mem[5..11], no drop/dup.
//  4. start_i re-asserted mid-frame and coincident with done_o -> ignored; single filter_start_o per frame.
//  5. rst at pixel 6 -> valid=0 and busy_o=0 next cycle, no done_o; new start replays from mem[0].
//  6. End-to-end with median_filter (random RAM, random gap 0..3) -> filter output matches reference model,
//     filter done_o seen.

Source files
------------

// File: rtl/pixel_frame_source_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_valid_if : valid-only RGB pixel stream (no backpressure)
// Revision: 1.0
// ----------------------------------------------------------------------------
interface pixel_valid_if #(
  parameter int PIXEL_W = 8
);
  typedef struct packed {
    logic [PIXEL_W-1:0] red;
    logic [PIXEL_W-1:0] green;
    logic [PIXEL_W-1:0] blue;
  } pixel_t;

  logic   valid;
  pixel_t pixel;

  modport master (output valid, output pixel);
  modport slave  (input  valid, input  pixel);
endinterface
`default_nettype wire

// File: rtl/pixel_frame_source.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pixel_frame_source : streams one raster frame from a sync-read RAM as a
// gapped, pausable valid-only pixel stream.  Revision: 1.0
// ----------------------------------------------------------------------------
module pixel_frame_source #(
  parameter  int IMAGE_LEN    = 1080,
  parameter  int IMAGE_HEIGHT = 720,
  parameter  int GAP_W        = 4,
  parameter  int PIXEL_W      = 8,
  localparam int NPIX         = IMAGE_LEN * IMAGE_HEIGHT,
  localparam int ADDR_W       = $clog2(NPIX)
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 start_i,
  input  wire logic [GAP_W-1:0]     gap_cycles_i,
  input  wire logic                 pause_i,
  output      logic [ADDR_W-1:0]    mem_rd_addr_o,
  input  wire logic [3*PIXEL_W-1:0] mem_rd_data_i,
  output      logic                 filter_start_o,
  output      logic                 busy_o,
  output      logic                 done_o,
  pixel_valid_if.master             pixel_valid_if_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [GAP_W-1:0]     gap_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic                 rd_pending_q;
  logic                 valid_q;
  logic [3*PIXEL_W-1:0] pixel_q;
  logic                 filter_start_q;
  logic                 busy_q;
  logic                 done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      gap_q          <= '0;
      gap_cnt_q      <= '0;
      rd_pending_q   <= 1'b0;
      valid_q        <= 1'b0;
      pixel_q        <= '0;
      filter_start_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      filter_start_q <= 1'b0;
      done_q         <= 1'b0;
      rd_pending_q   <= 1'b0;
      // RAM data for the read issued last cycle is present now
      valid_q        <= rd_pending_q;
      pixel_q        <= rd_pending_q ? mem_rd_data_i : '0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            gap_q          <= gap_cycles_i;
            addr_q         <= '0;
            filter_start_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= READ;
          end
        end
        READ: begin
          if (!pause_i) begin
            rd_pending_q <= 1'b1;
            if (addr_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              if (gap_q != '0) begin
                gap_cnt_q <= gap_q;
                state_q   <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (!pause_i) begin
            if (gap_cnt_q == GAP_W'(1)) begin
              state_q <= READ;
            end else begin
              gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
          end
        end
        DRAIN: begin
          // Stay in DRAIN during the done cycle so a coincident start is ignored
          if (done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (valid_q && !rd_pending_q) begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_addr_o          = addr_q;
  assign filter_start_o         = filter_start_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign pixel_valid_if_o.valid = valid_q;
  assign pixel_valid_if_o.pixel = pixel_q;

endmodule
`default_nettype wire
